tmds_decoder: RTL
=================

Name: tmds_decoder

Overview:
Receive-side counterpart of the TMDS encoder for one HDMI/DVI channel. It sits downstream of a 1:10 deserializer in the pixel clock domain and turns 10-bit TMDS characters back into 8-bit pixel data, 2-bit control values and a video-enable flag. It also runs a word-alignment state machine that watches for control tokens during blanking. When alignment fails, it requests a bitslip from the deserializer and reports lock status.

Parameters:
TOKEN_RUN, 8, consecutive control tokens needed to declare lock
SEARCH_CYCLES, 2048, cycles in SEARCH without lock before a bitslip is requested (must exceed one 720p line, 1650)
SLIP_WAIT, 16, cycles to wait after a bitslip before searching again
LOSS_CYCLES, 4096, cycles in LOCKED without any control token before lock is dropped

Ports:
clk_pixel_in  input  1  pixel clock; all logic is on this edge
rst_in  input  1  asynchronous, active-low reset
tmds_in  input  10  parallel TMDS character from the deserializer, bit 0 = first bit on the wire
data_out  output  8  decoded pixel byte
control_out  output  2  last decoded control value; for the blue channel, bit0 = hsync and bit1 = vsync
ve_out  output  1  1 = current character is data (active video), 0 = control token
aligned_out  output  1  1 while the FSM is in LOCKED
bitslip_out  output  1  one-cycle pulse asking the deserializer to shift the word boundary by 1 bit

Behaviour:
- Reset (rst_in=0, asynchronous):
  - All outputs go to 0.
  - FSM goes to SEARCH.
  - All counters go to 0.
  - Both pipeline stages are cleared.
- Reset deasserts synchronously to clk_pixel_in; the first capture happens on the first rising edge after rst_in=1.
- Pipeline: latency is 2 cycles from tmds_in to the decoded outputs.
  - Stage 1 registers tmds_in and a token flag plus the 2-bit token value.
  - Stage 2 registers data_out, control_out and ve_out.
- Control tokens (exact 10-bit match):
  - 1101010100 -> 00
  - 0010101011 -> 01
  - 0101010100 -> 10
  - 1010101011 -> 11
- On a token:
  - ve_out=0.
  - control_out takes the token value.
  - data_out=0.
- On any other character:
  - ve_out=1.
  - control_out holds its previous value.
  - data_out is decoded as below.
- Data decode:
  - q = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0].
  - d[0]=q[0].
  - For i=1..7: d[i] = q[i]^q[i-1] if tmds_in[8]=1, else ~(q[i]^q[i-1]).
  - No disparity checking.
- Decoding runs in every FSM state; aligned_out qualifies the result downstream.
- FSM states: SEARCH, SLIP_WAIT, LOCKED. Counters (run, cycle, wait) operate on the stage-1 token flag.
- SEARCH:
  - run counter increments on each token and clears on each non-token.
  - Cycle counter increments every cycle.
  - When the run counter reaches TOKEN_RUN -> LOCKED; aligned_out=1 on the next edge.
  - Else, when the cycle counter reaches SEARCH_CYCLES-1 -> assert bitslip_out for exactly one cycle and go to SLIP_WAIT.
  - If lock and timeout happen on the same cycle, lock wins and no bitslip is issued.
- SLIP_WAIT:
  - Counts SLIP_WAIT cycles, then returns to SEARCH with run and cycle counters cleared.
  - Tokens are ignored in this state.
- LOCKED:
  - Loss counter clears on any token and increments otherwise.
  - When it reaches LOSS_CYCLES-1 -> SEARCH with counters cleared; aligned_out drops on the same edge.
  - Bitslip is never issued in LOCKED.
- Counter widths: $clog2(max parameter)+1. Counters saturate and never wrap.
- bitslip_out is never high on two consecutive cycles.
- Reset applied mid-lock returns the block to the reset state immediately.

Decomposition:
- Shared package tmds_pkg holds:
  - the four 10-bit control-token constants, also used by tmds_encoder;
  - the enum typedef for the alignment states.
- One natural sub-module, tmds_word_decode: purely combinational. Maps 10 bits to {is_token, ctrl[1:0], data[7:0]}.
- The pipeline registers and FSM live in tmds_decoder.

Test Plan:
- Reset check: hold rst_in=0 while driving tokens -> all outputs 0. Release reset, drive 1101010100 -> two cycles later control_out=00, ve_out=0.
- Token and data decode: drive 0101010100 then 0100000000 then 1011111111 on consecutive cycles ->
  - first output: control_out=10, ve_out=0;
  - then data_out=8'h00, ve_out=1, control_out still 10;
  - then data_out=8'hFE.
- Lock: with TOKEN_RUN=8, drive 7 tokens, 1 data word, then 8 tokens -> aligned_out rises 2 cycles after the 8th token of the second run, not after the first run.
- Bitslip: with SEARCH_CYCLES=64 and SLIP_WAIT=4, drive only data words ->
  - bitslip_out is a single-cycle pulse every 68 cycles;
  - aligned_out stays 0.
- Loss of lock: lock, then with LOSS_CYCLES=32 drive 31 data words, 1 token, then 32 data words -> aligned_out stays 1 through the first stretch and falls after the second.
- Async reset mid-lock: assert rst_in=0 between clock edges while LOCKED -> aligned_out and ve_out go to 0 without a clock edge. After release, relock requires a full new TOKEN_RUN.

Source files
------------

// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control tokens shared by the encoder and decoder, plus the word-alignment state type
package tmds_pkg;
  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;
  typedef enum logic [1:0] {ST_SEARCH, ST_SLIP_WAIT, ST_LOCKED} align_state_e;
endpackage

// File: rtl/tmds_word_decode.sv
// tmds_word_decode: combinational map of one 10-bit TMDS character to token flag, control value and data byte
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] word,
  output logic       is_token,
  output logic [1:0] ctrl,
  output logic [7:0] data
);
  logic [7:0] q;
  logic [6:0] x;
  assign q = word[9] ? ~word[7:0] : word[7:0];
  assign x = q[7:1] ^ q[6:0];
  assign data = {word[8] ? x : ~x, q[0]};
  assign is_token = word inside {TOKEN_00, TOKEN_01, TOKEN_10, TOKEN_11};
  assign ctrl = word == TOKEN_01 ? 2'b01 : word == TOKEN_10 ? 2'b10 : word == TOKEN_11 ? 2'b11 : 2'b00;
endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: two-stage TMDS character decoder with control-token word alignment and bitslip requests
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN     = 8,
  parameter int SEARCH_CYCLES = 2048,
  parameter int SLIP_WAIT     = 16,
  parameter int LOSS_CYCLES   = 4096
) (
  input  logic       clk_pixel_in,
  input  logic       rst_in,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic [1:0] control_out,
  output logic       ve_out,
  output logic       aligned_out,
  output logic       bitslip_out
);
  localparam int MAX_AB = TOKEN_RUN > SEARCH_CYCLES ? TOKEN_RUN : SEARCH_CYCLES;
  localparam int MAX_CD = SLIP_WAIT > LOSS_CYCLES ? SLIP_WAIT : LOSS_CYCLES;
  localparam int CW = $clog2(MAX_AB > MAX_CD ? MAX_AB : MAX_CD) + 1;
  localparam logic [CW-1:0] RUN_LAST    = CW'(TOKEN_RUN - 1);
  localparam logic [CW-1:0] SEARCH_LAST = CW'(SEARCH_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(SLIP_WAIT - 1);
  localparam logic [CW-1:0] LOSS_LAST   = CW'(LOSS_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX     = '1;

  function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
    return v == CNT_MAX ? v : v + 1'b1;
  endfunction

  logic          tok, s1_tok, slip_n;
  logic [1:0]    tok_ctrl, s1_ctrl;
  logic [7:0]    tok_data, s1_data;
  logic [CW-1:0] run, run_n, cyc, cyc_n, wt, wt_n, loss, loss_n;
  align_state_e  state, state_n;

  tmds_word_decode u_decode (
    .word     (tmds_in),
    .is_token (tok),
    .ctrl     (tok_ctrl),
    .data     (tok_data)
  );

  // Counters not owned by the current state fall back to zero, so every entry starts clean.
  always_comb begin
    state_n = state;
    run_n = '0;
    cyc_n = '0;
    wt_n = '0;
    loss_n = '0;
    slip_n = 1'b0;
    case (state)
      ST_SEARCH:
        if (s1_tok && run == RUN_LAST) state_n = ST_LOCKED;
        else if (cyc == SEARCH_LAST) begin
          state_n = ST_SLIP_WAIT;
          slip_n = 1'b1;
        end else begin
          run_n = s1_tok ? inc(run) : '0;
          cyc_n = inc(cyc);
        end
      ST_SLIP_WAIT:
        if (wt == WAIT_LAST) state_n = ST_SEARCH;
        else wt_n = inc(wt);
      ST_LOCKED:
        if (!s1_tok && loss == LOSS_LAST) state_n = ST_SEARCH;
        else loss_n = s1_tok ? '0 : inc(loss);
      default: state_n = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk_pixel_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_tok <= 1'b0;
      s1_ctrl <= '0;
      s1_data <= '0;
      data_out <= '0;
      control_out <= '0;
      ve_out <= 1'b0;
      bitslip_out <= 1'b0;
      state <= ST_SEARCH;
      run <= '0;
      cyc <= '0;
      wt <= '0;
      loss <= '0;
    end else begin
      s1_tok <= tok;
      s1_ctrl <= tok_ctrl;
      s1_data <= tok_data;
      data_out <= s1_tok ? '0 : s1_data;
      control_out <= s1_tok ? s1_ctrl : control_out;
      ve_out <= !s1_tok;
      bitslip_out <= slip_n;
      state <= state_n;
      run <= run_n;
      cyc <= cyc_n;
      wt <= wt_n;
      loss <= loss_n;
    end
  end

  assign aligned_out = state == ST_LOCKED;
endmodule
